// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: Funct3 access
// encodings and the request FSM state type.
`timescale 1ns/1ps
package dmem_pkg;

    // Funct3 encodings (instruction bits 14:12) for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Request FSM: one request walks IDLE -> ACCESS -> RESP -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous read, per-byte write enables.
// Contents are deliberately not reset.
`timescale 1ns/1ps
module dmem_ram #(
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic [DM_ADDRESS-3:0] i_addr,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-masked write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the data RAM. One request every three cycles:
// accept (IDLE) -> ACCESS (RAM word available, store written on exit) ->
// RESP (resp_valid pulse). Lane extraction, sign/zero extension and byte
// enable generation live here.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- reject misaligned
// halfword/word accesses with err instead of force-aligning them.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. There is no response backpressure:
// resp_valid is a one-cycle pulse and rd/err hold until the next response.
`timescale 1ns/1ps
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic                  err,
    output state_t                o_dbg_state
);

    state_t                r_state;
    state_t                w_next;
    logic [DM_ADDRESS-1:0] r_a;
    logic [DATA_W-1:0]     r_wd;
    logic [2:0]            r_f3;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic [DATA_W-1:0]     r_rd;
    logic                  r_err;

    logic                  w_accept;
    logic [DM_ADDRESS-3:0] w_ram_addr;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_f3_ok;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_do_write;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_W-1:0]     w_load_val;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign o_dbg_state = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ST_ACCESS;
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_wd    <= '0;
            r_f3    <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_wd    <= wd;
            r_f3    <= Funct3;
            r_rd_en <= MemRead;
            r_wr_en <= MemWrite;
        end
    end

    // The RAM reads the incoming address on the accept edge so the word is
    // already on w_rdata during ACCESS; afterwards it follows the held address.
    assign w_ram_addr = w_accept ? a[DM_ADDRESS-1:2] : r_a[DM_ADDRESS-1:2];

    // Decode the held request: legality, alignment and store lane enables
    always_comb begin
        w_is_store = r_wr_en;
        w_is_load  = r_rd_en && !r_wr_en;
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = r_wd;
        if (w_is_store) begin
            w_f3_ok = (r_f3 == F3_B) || (r_f3 == F3_H) || (r_f3 == F3_W);
        end else if (w_is_load) begin
            w_f3_ok = (r_f3 == F3_B) || (r_f3 == F3_H) || (r_f3 == F3_W) ||
                      (r_f3 == F3_BU) || (r_f3 == F3_HU);
        end
        if (r_f3[1:0] == 2'b01) w_misalign = r_a[0];
        if (r_f3[1:0] == 2'b10) w_misalign = (r_a[1:0] != 2'b00);
        case (r_f3)
            F3_B: begin
                w_be    = 4'b0001 << r_a[1:0];
                w_wdata = {4{r_wd[7:0]}};
            end
            F3_H: begin
                w_be    = 4'b0011 << {r_a[1], 1'b0};
                w_wdata = {2{r_wd[15:0]}};
            end
            F3_W: begin
                w_be    = 4'b1111;
                w_wdata = r_wd;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = r_wd;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_err = (w_is_store || w_is_load) && (!w_f3_ok || w_misalign);
`else
    assign w_err = (w_is_store || w_is_load) && !w_f3_ok;
`endif

    // A reset landing on the ACCESS-exit edge cancels the write
    assign w_do_write = (r_state == ST_ACCESS) && w_is_store && !w_err && !reset;

    // Lane extraction: byte lane from a[1:0], halfword lane from a[1] only
    always_comb begin
        w_byte     = w_rdata[{r_a[1:0], 3'b000} +: 8];
        w_half     = w_rdata[{r_a[1], 4'b0000} +: 16];
        w_load_val = '0;
        case (r_f3)
            F3_B:    w_load_val = {{24{w_byte[7]}}, w_byte};
            F3_BU:   w_load_val = {24'h000000, w_byte};
            F3_H:    w_load_val = {{16{w_half[15]}}, w_half};
            F3_HU:   w_load_val = {16'h0000, w_half};
            F3_W:    w_load_val = w_rdata;
            default: w_load_val = '0;
        endcase
    end

    // Response data is formatted on the ACCESS-exit edge and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_err <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_err <= w_err;
            r_rd  <= (w_is_load && !w_err) ? w_load_val : '0;
        end
    end

    assign rd  = r_rd;
    assign err = r_err;

    dmem_ram #(
        .DM_ADDRESS(DM_ADDRESS)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_do_write),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DM_ADDRESS, default 9: byte-address width; depth = 2**(DM_ADDRESS-2) words.
REQ-002 Parameter DATA_W, default 32: data word width; only 32 is supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  access request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 MemRead  input  1  load request, from control unit.
REQ-008 MemWrite  input  1  store request, from control unit.
REQ-009 a  input  DM_ADDRESS  byte address, LSBs of ALU output.
REQ-010 wd  input  DATA_W  store data, right-aligned.
REQ-011 Funct3  input  3  instruction bits 14:12, selecting access size and sign.
REQ-012 resp_valid  output  1  one-cycle pulse; rd and err are valid.
REQ-013 rd  output  DATA_W  load result.
REQ-014 err  output  1  access rejected; no memory change.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL equal (state==IDLE).
REQ-016 IDLE SHALL go to ACCESS on req_valid; a, wd, Funct3, MemRead and MemWrite are registered in that cycle.
REQ-017 ACCESS SHALL go to RESP unconditionally; RESP SHALL go to IDLE unconditionally.
REQ-018 Throughput SHALL be one request per 3 cycles; accept at edge N gives resp_valid high in cycle N+2 only.
REQ-019 Loads SHALL support LB(000), LH(001), LW(010), LBU(100) and LHU(101), with byte or halfword lane select by a[1:0].
REQ-020 Sign-extension (LB, LH) and zero-extension (LBU, LHU) SHALL be applied to the selected lane.
REQ-021 Stores SHALL support SB(000), SH(001) and SW(010).
REQ-022 Store byte enables SHALL be SB 0001<<a[1:0], SH 0011<<a[1:0] and SW 1111.
REQ-023 Store data SHALL be replicated across lanes; only enabled bytes are written.
REQ-024 The store write SHALL occur at the ACCESS-exit edge.
REQ-025 The RAM read SHALL be synchronous; data is captured in ACCESS and formatted into rd at the ACCESS-exit edge.
REQ-026 When MemRead and MemWrite are both set, the access SHALL be a store.
REQ-027 When neither MemRead nor MemWrite is set, there SHALL be no access, and the response SHALL carry rd=0, err=0.
REQ-028 Any Funct3 not listed for the access type SHALL give no access, with err=1 and rd=0.
REQ-029 For stores, rd SHALL be 0 in the response.
REQ-030 rd and err SHALL hold their value until the next response.
REQ-031 Any address value is legal; no out-of-range condition exists.

Reset
REQ-032 Reset SHALL force state IDLE, resp_valid=0, rd=0 and err=0, with req_ready=1 in the following cycle.
REQ-033 Reset asserted during ACCESS SHALL suppress the pending write, and no response SHALL be produced.
REQ-034 Reset SHALL NOT clear memory contents.

Configuration
REQ-035 With DMEM_MISALIGN_TRAP_EN defined, the following accesses SHALL be rejected with err=1, no write, rd=0: LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0.
REQ-036 Without DMEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be force-aligned (LH/SH clear a[0]; LW/SW clear a[1:0]), and err reflects only REQ-028.

Structure
REQ-037 Package dmem_pkg SHALL hold the Funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
REQ-038 Sub-module dmem_ram SHALL provide a word array with synchronous read, per-byte write enables and parameter DM_ADDRESS.
REQ-039 Lane extraction, byte-enable generation and the FSM SHALL reside in dmem_lsu.

Verification
REQ-040 SW a=0x010 wd=0xDEADBEEF, then LW a=0x010 -> rd=0xDEADBEEF, err=0, resp_valid 2 cycles after each accept.
REQ-041 After REQ-040, SB a=0x011 wd=0x000000AA, then LB a=0x011 -> rd=0xFFFFFFAA; LBU a=0x011 -> 0x000000AA; LW a=0x010 -> 0xDEADAAEF.
REQ-042 SH a=0x022 wd=0x00008001, then LH a=0x022 -> 0xFFFF8001; LHU -> 0x00008001; LW a=0x020 -> 0x8001xxxx (low half unchanged).
REQ-043 LW a=0x013 -> with macro: err=1, rd=0, memory unchanged; without macro: rd=word@0x010, err=0.
REQ-044 Store with Funct3=011 -> err=1, memory unchanged.
REQ-045 Back-to-back req_valid held high -> accepts only when req_ready=1 (every third cycle).
REQ-046 Reset in the ACCESS cycle of SW a=0x030 -> no response, LW a=0x030 returns the prior value.
